alu_arbiter: RTL and testbench

- Shares the single combinational ALU instance between two requesters, e.g. the execute stage (port 0) and the address/branch helper (port 1).
- Per-requester valid/ready handshakes; round-robin arbitration; a 3-state FSM sequences operand issue, ALU evaluation and result return.
- Drives the ALU's srcA/srcB/ALUControl from registered operands and captures ALUResult/flags into a response register.

---
 rtl/alu_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. A round-robin grant is
// made in IDLE, the winner's operands are registered and presented to the ALU
// for one EXEC cycle, and the ALU result/flags are captured into the winner's
// response registers, which are held in RESP until the requester consumes them.
//
// Optional feature (macro ALU_ARB_ILLEGAL_OP_EN):
//   When defined, an opcode above MAX_OP is accepted but bypasses EXEC; the
//   owner gets result=0, flags=0, err=1 one cycle after acceptance and the
//   ALU-facing operand registers are left untouched. When undefined, every
//   opcode goes through the ALU and respN_err stays 0.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   reqN_valid / reqN_ready         request handshake for requester N (N=0,1)
//   reqN_srcA/srcB/ALUControl       operands and opcode for requester N
//   respN_valid / respN_ready       response handshake for requester N
//   respN_result/flags/err          captured ALUResult, {N,Z,C,V}, illegal-op
//   alu_srcA/srcB/ALUControl        registered operands to the shared ALU
//   alu_ALUResult/alu_flags         combinational ALU outputs
//   busy                            FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int MAX_OP = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_srcA,
    input  logic [DATA_W-1:0] req0_srcB,
    input  logic [CTRL_W-1:0] req0_ALUControl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_srcA,
    input  logic [DATA_W-1:0] req1_srcB,
    input  logic [CTRL_W-1:0] req1_ALUControl,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic [3:0]        resp0_flags,
    output logic              resp0_err,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic [3:0]        resp1_flags,
    output logic              resp1_err,
    output logic [DATA_W-1:0] alu_srcA,
    output logic [DATA_W-1:0] alu_srcB,
    output logic [CTRL_W-1:0] alu_ALUControl,
    input  logic [DATA_W-1:0] alu_ALUResult,
    input  logic [3:0]        alu_flags,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [CTRL_W-1:0] MAX_OP_C = CTRL_W'(MAX_OP);

`ifdef ALU_ARB_ILLEGAL_OP_EN
    localparam logic ILLEGAL_EN = 1'b1;
`else
    localparam logic ILLEGAL_EN = 1'b0;
`endif

    // Opcodes above the highest defined ALU operation are illegal.
    function automatic logic is_illegal_op(input logic [CTRL_W-1:0] ctrl);
        return (ctrl > MAX_OP_C);
    endfunction

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [CTRL_W-1:0] op_ctrl_q, op_ctrl_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] res0_q, res0_d, res1_q, res1_d;
    logic [3:0]        flg0_q, flg0_d, flg1_q, flg1_d;
    logic              err0_q, err0_d, err1_q, err1_d;

    logic              grant_valid_s;
    logic              grant_port_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_b_s;
    logic [CTRL_W-1:0] sel_ctrl_s;
    logic              skip_exec_s;

    // Round-robin grant: a lone requester wins; on contention the port that
    // did not win last time wins. The granted port's operands are selected.
    always_comb begin
        grant_valid_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_port_s = ~last_grant_q;
        end else if (req1_valid) begin
            grant_port_s = 1'b1;
        end else begin
            grant_port_s = 1'b0;
        end
        sel_a_s     = grant_port_s ? req1_srcA       : req0_srcA;
        sel_b_s     = grant_port_s ? req1_srcB       : req0_srcB;
        sel_ctrl_s  = grant_port_s ? req1_ALUControl : req0_ALUControl;
        skip_exec_s = ILLEGAL_EN & is_illegal_op(sel_ctrl_s);
    end

    // Ready is combinational and only asserted in IDLE; forced low while the
    // async reset is active so every output reads 0 during reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if ((state_q == ST_IDLE) && !reset && grant_valid_s) begin
            req0_ready = ~grant_port_s;
            req1_ready = grant_port_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Next-state logic for the IDLE/EXEC/RESP sequencer and its data registers.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctrl_d    = op_ctrl_q;
        resp_valid_d = resp_valid_q;
        res0_d       = res0_q;
        res1_d       = res1_q;
        flg0_d       = flg0_q;
        flg1_d       = flg1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    owner_d      = grant_port_s;
                    last_grant_d = grant_port_s;
                    if (skip_exec_s) begin
                        // Illegal op: answer directly, ALU operands untouched.
                        state_d = ST_RESP;
                        if (grant_port_s) begin
                            res1_d          = {DATA_W{1'b0}};
                            flg1_d          = 4'b0000;
                            err1_d          = 1'b1;
                            resp_valid_d[1] = 1'b1;
                        end else begin
                            res0_d          = {DATA_W{1'b0}};
                            flg0_d          = 4'b0000;
                            err0_d          = 1'b1;
                            resp_valid_d[0] = 1'b1;
                        end
                    end else begin
                        state_d   = ST_EXEC;
                        op_a_d    = sel_a_s;
                        op_b_d    = sel_b_s;
                        op_ctrl_d = sel_ctrl_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                if (owner_q) begin
                    res1_d          = alu_ALUResult;
                    flg1_d          = alu_flags;
                    err1_d          = 1'b0;
                    resp_valid_d[1] = 1'b1;
                end else begin
                    res0_d          = alu_ALUResult;
                    flg0_d          = alu_flags;
                    err0_d          = 1'b0;
                    resp_valid_d[0] = 1'b1;
                end
            end
            ST_RESP: begin
                if (owner_q ? resp1_ready : resp0_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 2'b00;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 2'b00;
            end
        endcase
    end

    // State and data registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_a_q       <= {DATA_W{1'b0}};
            op_b_q       <= {DATA_W{1'b0}};
            op_ctrl_q    <= {CTRL_W{1'b0}};
            resp_valid_q <= 2'b00;
            res0_q       <= {DATA_W{1'b0}};
            res1_q       <= {DATA_W{1'b0}};
            flg0_q       <= 4'b0000;
            flg1_q       <= 4'b0000;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctrl_q    <= op_ctrl_d;
            resp_valid_q <= resp_valid_d;
            res0_q       <= res0_d;
            res1_q       <= res1_d;
            flg0_q       <= flg0_d;
            flg1_q       <= flg1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign alu_srcA       = op_a_q;
    assign alu_srcB       = op_b_q;
    assign alu_ALUControl = op_ctrl_q;
    assign resp0_valid    = resp_valid_q[0];
    assign resp1_valid    = resp_valid_q[1];
    assign resp0_result   = res0_q;
    assign resp1_result   = res1_q;
    assign resp0_flags    = flg0_q;
    assign resp1_flags    = flg1_q;
    assign resp0_err      = err0_q;
    assign resp1_err      = err1_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_srcA, req0_srcB, req1_srcA, req1_srcB;
    logic [3:0]  req0_ALUControl, req1_ALUControl;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic [3:0]  resp0_flags, resp1_flags;
    logic        resp0_err, resp1_err;
    logic [31:0] alu_srcA, alu_srcB, alu_ALUResult;
    logic [3:0]  alu_ALUControl, alu_flags;
    logic        busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_srcA(req0_srcA), .req0_srcB(req0_srcB), .req0_ALUControl(req0_ALUControl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_srcA(req1_srcA), .req1_srcB(req1_srcB), .req1_ALUControl(req1_ALUControl),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_flags(resp0_flags), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_flags(resp1_flags), .resp1_err(resp1_err),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ALUControl(alu_ALUControl),
        .alu_ALUResult(alu_ALUResult), .alu_flags(alu_flags),
        .busy(busy)
    );

    // Stand-in for the shared ALU: 0=ADD, 1=SUB, anything else returns 0.
    logic [32:0] sum;
    always_comb begin
        sum           = 33'd0;
        alu_ALUResult = 32'd0;
        alu_flags     = 4'b0000;
        case (alu_ALUControl)
            4'd0: begin
                sum           = {1'b0, alu_srcA} + {1'b0, alu_srcB};
                alu_ALUResult = sum[31:0];
                alu_flags     = {sum[31], sum[31:0] == 32'd0, sum[32],
                                 (alu_srcA[31] == alu_srcB[31]) && (sum[31] != alu_srcA[31])};
            end
            4'd1: begin
                sum           = {1'b0, alu_srcA} + {1'b0, ~alu_srcB} + 33'd1;
                alu_ALUResult = sum[31:0];
                alu_flags     = {sum[31], sum[31:0] == 32'd0, sum[32],
                                 (alu_srcA[31] != alu_srcB[31]) && (sum[31] != alu_srcA[31])};
            end
            default: begin
                alu_ALUResult = 32'd0;
                alu_flags     = 4'b0000;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request on a port, check its ready, take the accept edge,
    // then withdraw the request. Returns #1 after the accept edge.
    task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl);
        if (port) begin
            req1_valid = 1'b1; req1_srcA = a; req1_srcB = b; req1_ALUControl = ctrl;
        end else begin
            req0_valid = 1'b1; req0_srcA = a; req0_srcB = b; req0_ALUControl = ctrl;
        end
        #1;
        chk("issue_ready0", {31'd0, req0_ready}, {31'd0, ~port});
        chk("issue_ready1", {31'd0, req1_ready}, {31'd0, port});
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Consume the pending response of a port.
    task automatic consume(input bit port);
        if (port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_srcA = 32'd0; req0_srcB = 32'd0; req0_ALUControl = 4'd0;
        req1_srcA = 32'd0; req1_srcB = 32'd0; req1_ALUControl = 4'd0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        chk("rst_alu_srcA", alu_srcA, 32'd0);
        chk("rst_result0", resp0_result, 32'd0);
        reset = 1'b0;
        step();

        // ADD 5+7 on port 0: EXEC cycle, then RESP at T+2.
        issue(1'b0, 32'd5, 32'd7, 4'd0);
        chk("add_exec_busy", {31'd0, busy}, 32'd1);
        chk("add_exec_alu_srcA", alu_srcA, 32'd5);
        chk("add_exec_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        step();
        chk("add_resp0_valid", {31'd0, resp0_valid}, 32'd1);
        chk("add_result", resp0_result, 32'd12);
        chk("add_flags", {28'd0, resp0_flags}, {28'd0, 4'b0000});
        chk("add_resp1_valid", {31'd0, resp1_valid}, 32'd0);
        consume(1'b0);
        chk("add_done_busy", {31'd0, busy}, 32'd0);

        // SUB 3-5 on port 1.
        issue(1'b1, 32'd3, 32'd5, 4'd1);
        step();
        chk("sub_resp1_valid", {31'd0, resp1_valid}, 32'd1);
        chk("sub_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        chk("sub_result", resp1_result, 32'hFFFF_FFFE);
        chk("sub_flags", {28'd0, resp1_flags}, {28'd0, 4'b1000});
        consume(1'b1);

        // ADD with wrap-around on port 0.
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 4'd0);
        step();
        chk("wrap_result", resp0_result, 32'd0);
        chk("wrap_flags", {28'd0, resp0_flags}, {28'd0, 4'b0110});
        consume(1'b0);

        // Fresh reset, then both ports valid for 4 ops: strict 0,1,0,1.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        req0_valid = 1'b1; req0_srcA = 32'd1;  req0_srcB = 32'd1; req0_ALUControl = 4'd0;
        req1_valid = 1'b1; req1_srcA = 32'd10; req1_srcB = 32'd3; req1_ALUControl = 4'd1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_idle_busy", {31'd0, busy}, 32'd0);
            chk("rr_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            step();
            chk("rr_exec_busy", {31'd0, busy}, 32'd1);
            chk("rr_exec_ready0", {31'd0, req0_ready}, 32'd0);
            step();
            chk("rr_resp_busy", {31'd0, busy}, 32'd1);
            if (i % 2 == 0) begin
                chk("rr_resp0_valid", {31'd0, resp0_valid}, 32'd1);
                chk("rr_resp0_result", resp0_result, 32'd2);
            end else begin
                chk("rr_resp1_valid", {31'd0, resp1_valid}, 32'd1);
                chk("rr_resp1_result", resp1_result, 32'd7);
                chk("rr_resp1_flags", {28'd0, resp1_flags}, {28'd0, 4'b0010});
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;

        // Backpressure on port 0 while port 1 waits.
        issue(1'b0, 32'd20, 32'd22, 4'd0);
        req1_valid = 1'b1; req1_srcA = 32'd9; req1_srcB = 32'd4; req1_ALUControl = 4'd1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp0_valid", {31'd0, resp0_valid}, 32'd1);
            chk("bp_result", resp0_result, 32'd42);
            chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
            step();
        end
        consume(1'b0);
        chk("bp_idle_busy", {31'd0, busy}, 32'd0);
        chk("bp_grant1", {31'd0, req1_ready}, 32'd1);
        chk("bp_resp0_cleared", {31'd0, resp0_valid}, 32'd0);
        step();
        req1_valid = 1'b0;
        chk("bp_exec_busy", {31'd0, busy}, 32'd1);
        step();
        chk("bp_resp1_valid", {31'd0, resp1_valid}, 32'd1);
        chk("bp_resp1_result", resp1_result, 32'd5);
        consume(1'b1);

        // Reset asserted during EXEC.
        issue(1'b0, 32'd100, 32'd1, 4'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_alu_srcA", alu_srcA, 32'd0);
        chk("mid_rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("mid_rst_no_resp", {31'd0, resp0_valid}, 32'd0);
        chk("mid_rst_idle", {31'd0, busy}, 32'd0);

        // Opcode 4'b1100: illegal-op path or plain ALU pass-through.
        issue(1'b0, 32'd7, 32'd8, 4'b1100);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("ill_resp0_valid", {31'd0, resp0_valid}, 32'd1);
        chk("ill_err", {31'd0, resp0_err}, 32'd1);
        chk("ill_result", resp0_result, 32'd0);
        chk("ill_alu_untouched", alu_srcA, 32'd0);
`else
        chk("op12_exec_valid", {31'd0, resp0_valid}, 32'd0);
        chk("op12_alu_srcA", alu_srcA, 32'd7);
        step();
        chk("op12_resp0_valid", {31'd0, resp0_valid}, 32'd1);
        chk("op12_err", {31'd0, resp0_err}, 32'd0);
        chk("op12_result", resp0_result, 32'd0);
`endif
        consume(1'b0);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
